// File: rtl/cursor_ctrl.sv
// Cursor controller for a 3x3 board.
// Five raw pushbuttons are synchronized, debounced and edge-detected. The
// resulting press events move a cursor over cells 0..8 (row-major) or strobe
// "set" to place a mark. While mode = 1 (score mode) all events are dropped,
// and the cursor snaps back to the centre cell when game mode resumes.
module cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    input  logic       mode,
    output logic [3:0] cursorPos,
    output logic       set
);

    localparam int NUM_BTN = 5;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);

    // Bit positions of each button inside the packed button vectors.
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_C = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       POS_CENTRE = 4'd4;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_prev;
    logic [NUM_BTN-1:0] press;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic               mode_q;
    logic [3:0]         next_pos;
    logic               next_set;

    assign raw = {btnC, btnU, btnD, btnL, btnR};

    // Column of a cell index (0..2).
    function automatic logic [1:0] col_of(input logic [3:0] p);
        case (p)
            4'd0, 4'd3, 4'd6: col_of = 2'd0;
            4'd1, 4'd4, 4'd7: col_of = 2'd1;
            default:          col_of = 2'd2;
        endcase
    endfunction

    // Row moves wrap top<->bottom, column moves wrap left<->right.
    function automatic logic [3:0] move_up(input logic [3:0] p);
        move_up = (p < 4'd3) ? p + 4'd6 : p - 4'd3;
    endfunction

    function automatic logic [3:0] move_down(input logic [3:0] p);
        move_down = (p > 4'd5) ? p - 4'd6 : p + 4'd3;
    endfunction

    function automatic logic [3:0] move_left(input logic [3:0] p);
        move_left = (col_of(p) == 2'd0) ? p + 4'd2 : p - 4'd1;
    endfunction

    function automatic logic [3:0] move_right(input logic [3:0] p);
        move_right = (col_of(p) == 2'd2) ? p - 4'd2 : p + 4'd1;
    endfunction

    // Two-flop synchronizer per raw button.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of statement order.
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Independent debouncer per button: level follows the synchronized input
    // only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
            // NOTE: the counter array is real control state (a partial count
            // must be discarded on reset), so every entry is reset explicitly.
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync_b[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync_b[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Registered rising-edge detect of debounced levels and mode history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_prev <= '0;
            press      <= '0;
            mode_q     <= 1'b0;
        end else begin
            level_prev <= level;
            press      <= level & ~level_prev;
            mode_q     <= mode;
        end
    end

    // Pick the single highest-priority event (C > U > D > L > R) and apply it.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        next_pos = cursorPos;
        next_set = 1'b0;
        if (!mode) begin
            if (mode_q) begin
                next_pos = POS_CENTRE;
            end else if (press[BTN_C]) begin
                next_set = 1'b1;
            end else if (press[BTN_U]) begin
                next_pos = move_up(cursorPos);
            end else if (press[BTN_D]) begin
                next_pos = move_down(cursorPos);
            end else if (press[BTN_L]) begin
                next_pos = move_left(cursorPos);
            end else if (press[BTN_R]) begin
                next_pos = move_right(cursorPos);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursorPos <= POS_CENTRE;
            set       <= 1'b0;
        end else begin
            cursorPos <= next_pos;
            set       <= next_set;
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl with DEBOUNCE_CYCLES = 4.
// Stimulus pushes {cycle, cursorPos, set} expectations; a negedge monitor
// pops one whenever the DUT shows a set pulse or a cursor change.
module tb_cursor_ctrl;

    localparam int DB = 4;
    // Input driven just after edge e is first sampled at e+1; effect is
    // visible after edge (e+1)+DB+3.
    localparam int LAT = DB + 4;

    localparam int R = 0;
    localparam int L = 1;
    localparam int D = 2;
    localparam int U = 3;
    localparam int C = 4;

    typedef struct {
        int         cyc;
        logic [3:0] pos;
        logic       set_bit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [4:0] btn = '0;
    logic [3:0] cursorPos;
    logic       set;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [3:0] last_pos = 4'd4;

    cursor_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btnU      (btn[U]),
        .btnD      (btn[D]),
        .btnL      (btn[L]),
        .btnR      (btn[R]),
        .btnC      (btn[C]),
        .mode      (mode),
        .cursorPos (cursorPos),
        .set       (set)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int c, input logic [3:0] p, input logic s);
        exp_t e;
        e.cyc     = c;
        e.pos     = p;
        e.set_bit = s;
        exp_q.push_back(e);
    endtask

    // Hold the buttons in mask high for hi cycles, then low for lo cycles.
    task automatic press(input logic [4:0] mask, input int hi, input int lo,
                         input bit ev, input logic [3:0] p, input logic s);
        if (ev) expect_at(cyc + LAT, p, s);
        btn = btn | mask;
        tick(hi);
        btn = btn & ~mask;
        tick(lo);
    endtask

    // Monitor: every set pulse or cursor change consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_pos = cursorPos;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: nothing seen at cyc=%0d, expected pos=%0d set=%0b",
                         e.cyc, e.pos, e.set_bit);
            end
            if (cursorPos != last_pos || set) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d pos=%0d set=%0b, expected no change",
                             cyc, cursorPos, set);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pos != cursorPos || e.set_bit != set) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d pos=%0d set=%0b, expected cyc=%0d pos=%0d set=%0b",
                                 cyc, cursorPos, set, e.cyc, e.pos, e.set_bit);
                    end
                end
                last_pos = cursorPos;
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b0;
        #2;
        check("reset_pos", int'(cursorPos), 4);
        check("reset_set", int'(set), 0);
        tick(3);
        rst = 1'b1;
        tick(3);

        // Centre press: one set pulse, cursor stays; long hold, no repeat.
        press(5'b1 << C, 15, 10, 1'b1, 4'd4, 1'b1);

        // Moves with wraps.
        press(5'b1 << U, 10, 10, 1'b1, 4'd1, 1'b0);
        press(5'b1 << U, 10, 10, 1'b1, 4'd7, 1'b0);
        press(5'b1 << L, 10, 10, 1'b1, 4'd6, 1'b0);
        press(5'b1 << L, 10, 10, 1'b1, 4'd8, 1'b0);
        press(5'b1 << D, 10, 10, 1'b1, 4'd2, 1'b0);
        press(5'b1 << R, 10, 10, 1'b1, 4'd0, 1'b0);
        press(5'b1 << L, 10, 10, 1'b1, 4'd2, 1'b0);
        press(5'b1 << R, 10, 10, 1'b1, 4'd0, 1'b0);
        press(5'b1 << U, 10, 10, 1'b1, 4'd6, 1'b0);
        press(5'b1 << D, 10, 10, 1'b1, 4'd0, 1'b0);
        press(5'b1 << D, 10, 10, 1'b1, 4'd3, 1'b0);
        press(5'b1 << R, 10, 10, 1'b1, 4'd4, 1'b0);

        // Short pulses (3 high, 2 low) never reach the debounce threshold.
        for (int i = 0; i < 8; i++) press(5'b1 << R, 3, 2, 1'b0, 4'd0, 1'b0);
        tick(10);
        check("short_pulse_pos", int'(cursorPos), 4);

        // C and U together: only C acts.
        press((5'b1 << C) | (5'b1 << U), 10, 15, 1'b1, 4'd4, 1'b1);

        // Move to 8, then score mode discards events.
        press(5'b1 << R, 10, 10, 1'b1, 4'd5, 1'b0);
        press(5'b1 << D, 10, 10, 1'b1, 4'd8, 1'b0);
        mode = 1'b1;
        tick(2);
        press(5'b1 << C, 10, 10, 1'b0, 4'd0, 1'b0);
        press(5'b1 << R, 10, 10, 1'b0, 4'd0, 1'b0);
        // L event lands on the cycle mode falls: discarded, cursor recentres.
        btn[L] = 1'b1;
        tick(DB + 3);
        mode = 1'b0;
        expect_at(cyc + 1, 4'd4, 1'b0);
        tick(10);
        btn[L] = 1'b0;
        tick(10);

        // Reset mid-debounce of btnD (counter at 3).
        press(5'b1 << U, 10, 10, 1'b1, 4'd1, 1'b0);
        press(5'b1 << L, 10, 10, 1'b1, 4'd0, 1'b0);
        btn[D] = 1'b1;
        tick(5);
        #3 rst = 1'b0;
        #1;
        check("midreset_pos", int'(cursorPos), 4);
        check("midreset_set", int'(set), 0);
        btn[D] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(20);
        press(5'b1 << D, 10, 10, 1'b1, 4'd7, 1'b0);

        // Button held across reset release fires once, DB+3 edges later.
        rst = 1'b0;
        btn[U] = 1'b1;
        tick(3);
        rst = 1'b1;
        expect_at(cyc + LAT, 4'd1, 1'b0);
        tick(15);
        btn[U] = 1'b0;
        tick(15);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
